// File: rtl/param_mux_scan.sv
// param_mux_scan: registered N-channel mux with manual select and an
// optional round-robin scan mode.
// Scan mode is built only when the macro PARAM_MUX_SCAN_SCAN_EN is defined;
// otherwise mode is ignored and the channel changes only on sel_load.
module param_mux_scan #(
   parameter  int WIDTH    = 1,
   parameter  int CHANNELS = 4,
   parameter  int DWELL    = 8,
   localparam int SELW     = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   input  logic [SELW-1:0]           sel,
   input  logic                      sel_load,
   input  logic                      mode,
   input  logic                      hold,
   output logic [WIDTH-1:0]          data_out,
   output logic [SELW-1:0]           ch_out,
   output logic                      valid,
   output logic                      switched
);

   // Channel k of the flat input bus, indexable by a SELW-bit channel number
   logic [WIDTH-1:0] ch_data [CHANNELS];

   for (genvar k = 0; k < CHANNELS; k++) begin : g_split
      assign ch_data[k] = data_in[k*WIDTH +: WIDTH];
   end

   logic [SELW-1:0]  cur_q, cur_d;
   logic [SELW-1:0]  prev_q;
   logic [WIDTH-1:0] dout_q;
   logic [SELW-1:0]  ch_q;
   logic             valid_q;
   logic             switched_q;

`ifdef PARAM_MUX_SCAN_SCAN_EN
   localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

   logic [7:0] cnt_q, cnt_d;

   // Next channel/dwell count: load wins, manual parks cnt at 0, scan advances
   always_comb begin
      cur_d = cur_q;
      cnt_d = cnt_q;
      if (sel_load) begin
         cur_d = sel;
         cnt_d = '0;
      end else if (!mode) begin
         cnt_d = '0;
      end else if (!hold) begin
         if (cnt_q == DWELL_LAST) begin
            cnt_d = '0;
            cur_d = cur_q + SELW'(1);
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   // Dwell counter; reset discards any partial dwell
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   // Scan hardware is absent; mode is kept as a port but has no effect
   logic unused_mode;
   assign unused_mode = mode;

   // Next channel changes only on an explicit load
   always_comb begin
      cur_d = cur_q;
      if (sel_load) begin
         cur_d = sel;
      end
   end
`endif

   // Channel state, output sampling and the change-detect pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_q      <= '0;
         prev_q     <= '0;
         dout_q     <= '0;
         ch_q       <= '0;
         valid_q    <= 1'b0;
         switched_q <= 1'b0;
      end else begin
         cur_q      <= cur_d;
         prev_q     <= cur_q;
         // prev_q lags cur_q by one edge, so the pulse lines up with ch_out
         switched_q <= (cur_q != prev_q);
         if (!hold) begin
            dout_q  <= ch_data[cur_q];
            ch_q    <= cur_q;
            valid_q <= 1'b1;
         end
      end
   end

   assign data_out = dout_q;
   assign ch_out   = ch_q;
   assign valid    = valid_q;
   assign switched = switched_q;

endmodule

// File: tb/tb_param_mux_scan.sv
// Directed bench for param_mux_scan with a per-cycle expectation queue.
module tb_param_mux_scan;

   localparam int WIDTH    = 1;
   localparam int CHANNELS = 4;
   localparam int DWELL    = 3;
   localparam int SELW     = 2;

   logic                      clk;
   logic                      rst;
   logic [CHANNELS*WIDTH-1:0] data_in;
   logic [SELW-1:0]           sel;
   logic                      sel_load;
   logic                      mode;
   logic                      hold;
   logic [WIDTH-1:0]          data_out;
   logic [SELW-1:0]           ch_out;
   logic                      valid;
   logic                      switched;

   param_mux_scan #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS),
      .DWELL    (DWELL)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .sel      (sel),
      .sel_load (sel_load),
      .mode     (mode),
      .hold     (hold),
      .data_out (data_out),
      .ch_out   (ch_out),
      .valid    (valid),
      .switched (switched)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] dout;
      logic [SELW-1:0]  ch;
      logic             vld;
      logic             sw;
   } exp_t;

   exp_t sbq[$];

   int checks   = 0;
   int failures = 0;

   // Reference state of the channel selector
   logic [SELW-1:0]  m_cur;
   int               m_cnt;
   logic [SELW-1:0]  m_prev;
   logic [WIDTH-1:0] m_dout;
   logic [SELW-1:0]  m_ch;
   logic             m_vld;

   // Most recent observed outputs, for directed checks
   logic [WIDTH-1:0] last_dout;
   logic [SELW-1:0]  last_ch;
   logic             last_vld;
   int               swcnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_cur  = '0;
      m_cnt  = 0;
      m_prev = '0;
      m_dout = '0;
      m_ch   = '0;
      m_vld  = 1'b0;
   endtask

   // Predict the next edge from current inputs, push it, clock, then compare
   task automatic cycle();
      exp_t e;
      exp_t got;
      logic [SELW-1:0] n_cur;
      int n_cnt;
      if (!hold) begin
         e.dout = data_in[int'(m_cur)];
         e.ch   = m_cur;
         e.vld  = 1'b1;
      end else begin
         e.dout = m_dout;
         e.ch   = m_ch;
         e.vld  = m_vld;
      end
      e.sw  = (m_cur != m_prev);
      n_cur = m_cur;
      n_cnt = m_cnt;
      if (sel_load) begin
         n_cur = sel;
         n_cnt = 0;
      end
`ifdef PARAM_MUX_SCAN_SCAN_EN
      else if (!mode) begin
         n_cnt = 0;
      end else if (!hold) begin
         if (m_cnt == DWELL - 1) begin
            n_cnt = 0;
            n_cur = SELW'((int'(m_cur) + 1) % CHANNELS);
         end else begin
            n_cnt = m_cnt + 1;
         end
      end
`endif
      m_prev = m_cur;
      m_cur  = n_cur;
      m_cnt  = n_cnt;
      m_dout = e.dout;
      m_ch   = e.ch;
      m_vld  = e.vld;
      sbq.push_back(e);

      @(posedge clk);
      #1;
      got = sbq.pop_front();
      chk("data_out", 32'(data_out), 32'(got.dout));
      chk("ch_out",   32'(ch_out),   32'(got.ch));
      chk("valid",    32'(valid),    32'(got.vld));
      chk("switched", 32'(switched), 32'(got.sw));
      last_dout = data_out;
      last_ch   = ch_out;
      last_vld  = valid;
      if (switched === 1'b1) swcnt++;
   endtask

   // Pulse rst between clock edges and check outputs clear without a clock
   task automatic async_reset(input string tag);
      #3;
      rst = 1'b1;
      #1;
      chk({tag, "_dout"},  32'(data_out), 32'd0);
      chk({tag, "_ch"},    32'(ch_out),   32'd0);
      chk({tag, "_valid"}, 32'(valid),    32'd0);
      chk({tag, "_sw"},    32'(switched), 32'd0);
      model_reset();
      #2;
      rst = 1'b0;
   endtask

`ifdef PARAM_MUX_SCAN_SCAN_EN
   int exp_seq [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
   logic [SELW-1:0] held_ch;
`else
   logic [SELW-1:0] ch0;
`endif

   initial begin
      rst      = 1'b1;
      data_in  = '0;
      sel      = '0;
      sel_load = 1'b0;
      mode     = 1'b0;
      hold     = 1'b0;
      swcnt    = 0;
      model_reset();

      #1;
      chk("rst_dout",  32'(data_out), 32'd0);
      chk("rst_ch",    32'(ch_out),   32'd0);
      chk("rst_valid", 32'(valid),    32'd0);
      chk("rst_sw",    32'(switched), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Manual selection
      data_in = 4'b0100;
      cycle();
      chk("valid_first", 32'(last_vld), 32'd1);
      cycle();
      swcnt    = 0;
      sel      = 2'd2;
      sel_load = 1'b1;
      cycle();
      sel_load = 1'b0;
      cycle();
      chk("man_dout", 32'(last_dout), 32'd1);
      chk("man_ch",   32'(last_ch),   32'd2);
      cycle();
      chk("man_sw_count", 32'(swcnt), 32'd1);

      // Reloading the same channel must not pulse switched
      swcnt    = 0;
      sel_load = 1'b1;
      cycle();
      sel_load = 1'b0;
      cycle();
      cycle();
      chk("same_sw_count", 32'(swcnt), 32'd0);

      // Hold freezes outputs; a load during hold still moves the channel
      hold    = 1'b1;
      data_in = 4'b1011;
      cycle();
      cycle();
      chk("hold_dout", 32'(last_dout), 32'd1);
      chk("hold_ch",   32'(last_ch),   32'd2);
      sel      = 2'd1;
      sel_load = 1'b1;
      cycle();
      sel_load = 1'b0;
      cycle();
      chk("hold_ch_frozen", 32'(last_ch), 32'd2);
      hold = 1'b0;
      cycle();
      chk("unhold_ch",   32'(last_ch),   32'd1);
      chk("unhold_dout", 32'(last_dout), 32'd1);

      // Asynchronous reset mid-operation, then first edge revalidates at ch 0
      async_reset("rst_manual");
      cycle();
      chk("rel_valid", 32'(last_vld), 32'd1);
      chk("rel_ch",    32'(last_ch),  32'd0);

`ifdef PARAM_MUX_SCAN_SCAN_EN
      // Scan wrap from a fresh reset
      data_in = 4'b0110;
      async_reset("rst_prescan");
      mode  = 1'b1;
      swcnt = 0;
      for (int i = 0; i < 13; i++) begin
         cycle();
         chk("scan_seq", 32'(last_ch), 32'(exp_seq[i]));
      end
      chk("scan_sw_count", 32'(swcnt), 32'd4);

      // Load on the same edge as an advance out of channel 2
      for (int i = 0; i < 16; i++) begin
         if (m_cur == 2'd2 && m_cnt == DWELL - 1) break;
         cycle();
      end
      sel      = 2'd1;
      sel_load = 1'b1;
      cycle();
      sel_load = 1'b0;
      for (int i = 0; i < DWELL; i++) begin
         cycle();
         chk("prio_ch1", 32'(last_ch), 32'd1);
      end

      // Hold mid-dwell for 5 cycles
      for (int i = 0; i < 8; i++) begin
         if (m_cnt == 1) break;
         cycle();
      end
      hold    = 1'b1;
      held_ch = last_ch;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("scan_hold_ch", 32'(last_ch), 32'(held_ch));
      end
      hold = 1'b0;
      for (int i = 0; i < 4; i++) cycle();

      // Reset while dwelling on channel 3
      for (int i = 0; i < 16; i++) begin
         if (m_cur == 2'd3 && m_cnt == 1) break;
         cycle();
      end
      async_reset("rst_scan");
      cycle();
      chk("scan_rel_valid", 32'(last_vld), 32'd1);
      chk("scan_rel_ch",    32'(last_ch),  32'd0);
      for (int i = 0; i < DWELL + 1; i++) cycle();
      chk("scan_rel_full_dwell", 32'(last_ch), 32'd1);
`else
      // Without the scan build, mode has no effect
      mode  = 1'b1;
      swcnt = 0;
      ch0   = last_ch;
      for (int i = 0; i < 20; i++) begin
         cycle();
         chk("off_ch_const", 32'(last_ch), 32'(ch0));
      end
      chk("off_sw_count", 32'(swcnt), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/param_mux_scan.md
PARAM_MUX_SCAN -- requirements
Module: param_mux_scan

Interface
REQ-001 SHALL have parameter WIDTH, default 1: bits per channel, legal 1..8.
REQ-002 SHALL have parameter CHANNELS, default 4: input channel count, power of two, legal 2..16.
REQ-003 SHALL have parameter DWELL, default 8: clock cycles per channel in scan mode, legal 1..256.
REQ-004 SHALL define SELW = log2(CHANNELS), the width of every channel-index signal.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port data_in, input, CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port sel, input, SELW: requested channel index.
REQ-009 SHALL have port sel_load, input, 1: single-cycle strobe that loads sel into the current channel.
REQ-010 SHALL have port mode, input, 1: 0 = manual, 1 = scan.
REQ-011 SHALL have port hold, input, 1: freezes the current channel and the dwell counter.
REQ-012 SHALL have port data_out, output, WIDTH: registered selected data.
REQ-013 SHALL have port ch_out, output, SELW: index of the channel that data_out was sampled from.
REQ-014 SHALL have port valid, output, 1: data_out holds a real sample.
REQ-015 SHALL have port switched, output, 1: one-cycle pulse when the current channel changes.

Function
REQ-016 SHALL keep the internal registers cur (SELW bits) and cnt (8 bits).
REQ-017 SHALL update data_out <= data_in[cur] and ch_out <= cur every cycle, except while hold=1, which gives 1-cycle latency from cur to data_out.
REQ-018 SHALL, when sel_load=1, set cur <= sel and cnt <= 0 on that edge, in either mode and regardless of hold; sel_load has priority over scan advance.
REQ-019 SHALL, in manual mode (mode=0), change cur only on sel_load and keep cnt at 0.
REQ-020 SHALL, in scan mode with hold=0 and sel_load=0, increment cnt; when cnt = DWELL-1, set cnt <= 0 and cur <= cur+1 mod CHANNELS, wrapping from CHANNELS-1 to 0.
REQ-021 SHALL, when DWELL=1, advance cur on every scan-mode cycle.
REQ-022 SHALL, while hold=1 and sel_load=0, freeze cur, cnt, data_out and ch_out.
REQ-023 SHALL pulse switched=1 for exactly one cycle, on the edge after cur takes a different value; loading the same index produces no pulse.
REQ-024 SHALL set valid=1 on the first edge that samples data_out after reset deasserts, and keep it at 1 until the next reset.
REQ-025 SHALL, on a mode change from 1 to 0, retain cur and clear cnt; on a change from 0 to 1, start dwell counting from cnt=0 at the current channel.

Reset
REQ-026 SHALL, while rst=1, immediately force data_out=0, ch_out=0, valid=0, switched=0, cur=0 and cnt=0, independent of clk.
REQ-027 SHALL, when rst asserts mid-dwell, discard the dwell progress; after release, scanning resumes at channel 0 with a full DWELL period.

Configuration
REQ-028 SHALL gate scan mode with the macro PARAM_MUX_SCAN_SCAN_EN; when it is defined, behaviour is as REQ-020/021/025.
REQ-029 SHALL, when PARAM_MUX_SCAN_SCAN_EN is undefined, ignore mode, omit the cnt logic, and keep cur changing only on sel_load; all ports remain present.

Verification
REQ-030 Manual: WIDTH=1, CHANNELS=4, data_in=4'b0100, sel=2 with a sel_load pulse -> data_out=1 and ch_out=2 two edges later, switched pulses once.
REQ-031 Scan wrap: CHANNELS=4, DWELL=3, mode=1 -> ch_out sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; switched pulses 4 times.
REQ-032 Hold: scan with DWELL=8, hold=1 for 5 cycles at cnt=3 -> ch_out is unchanged and the channel advances 5 cycles later than without hold.
REQ-033 Load priority: sel_load with sel=1 on the same edge as scan advance from 2 -> cur=1, cnt=0, no visit to channel 3.
REQ-034 Async reset: rst pulsed between edges mid-scan at ch 3 -> all outputs read 0 immediately; after release valid=1 at the first edge, ch_out=0.
REQ-035 Macro off: build without PARAM_MUX_SCAN_SCAN_EN, mode=1 for 20 cycles -> ch_out is constant and switched stays 0.
